// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed 7-segment clock scanner with PWM dimming
// A frame is six digit slots; each slot starts with one blanked cycle so anodes never overlap.
module clock_display_scan #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DIGIT_RATE = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] hour_tens,
    input  logic [3:0] hour_units,
    input  logic       is_am,
    input  logic [2:0] brightness,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] an_n,
    output logic       frame_start
);

    localparam int TICKS = CLK_FREQ / DIGIT_RATE;
    localparam int TW = $clog2(TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

    logic [TW-1:0]   tick;
    logic [2:0]      digit;
    logic [2:0]      pwm_cnt;
    logic [5:0][3:0] snap_digits;
    logic            snap_am;

    logic [6:0] seg_next;
    logic       dp_next;
    logic [5:0] an_next;
    logic       load;
    logic [3:0] cur_val;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign load    = (digit == 3'd0) && (tick == '0);
    assign cur_val = snap_digits[digit];

    always_comb begin
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = 6'h3F;
        if (tick != '0) begin
            // Leading zero of the hour is blanked but its slot still scans.
            if (digit == 3'd5 && cur_val == 4'd0)
                seg_next = 7'h7F;
            else
                seg_next = decode(cur_val);
            if ((digit == 3'd2 || digit == 3'd4) && !snap_digits[0][0])
                dp_next = 1'b0;
            if (digit == 3'd0 && !snap_am)
                dp_next = 1'b0;
            if (pwm_cnt <= brightness)
                an_next = ~(6'b1 << digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= '0;
            digit       <= 3'd0;
            pwm_cnt     <= 3'd0;
            snap_digits <= '0;
            snap_am     <= 1'b1;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            an_n        <= 6'h3F;
            frame_start <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
            if (tick == TICK_LAST) begin
                tick  <= '0;
                digit <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
            end else begin
                tick <= tick + TW'(1);
            end
            if (load) begin
                snap_digits <= {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
                snap_am     <= is_am;
            end
            frame_start <= load;
            seg_n       <= seg_next;
            dp_n        <= dp_next;
            an_n        <= an_next;
        end
    end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter DIGIT_RATE, default 1200, meaning digit slots per second; TICKS = CLK_FREQ/DIGIT_RATE, and TICKS >= 2 is required.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports sec_tens, sec_units, min_tens, min_units, hour_tens, hour_units, input, 4 bits each: BCD time digits.
REQ-006 SHALL have port is_am, input, 1 bit: 1 = AM.
REQ-007 SHALL have port brightness, input, 3 bits: PWM duty in eighths minus one.
REQ-008 SHALL have port seg_n, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, with seg_n[0] = a.
REQ-009 SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-010 SHALL have port an_n, output, 6 bits: active-low digit enables; an_n[0] = sec_units, [1] = sec_tens, [2] = min_units, [3] = min_tens, [4] = hour_units, [5] = hour_tens.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each 6-digit frame.

Function
REQ-012 SHALL run tick counter 0..TICKS-1; at TICKS-1 it wraps to 0 and the digit index advances 0->1->...->5->0.
REQ-013 SHALL treat tick == 0 of every slot as dead time: an_n = 6'h3F, seg_n = 7'h7F, dp_n = 1.
REQ-014 SHALL load the snapshot (all six digits plus is_am) only in the cycle where digit == 0 and tick == 0; inputs changing at any other time SHALL NOT affect the display until the next load.
REQ-015 SHALL register all outputs; outputs in cycle t+1 reflect tick, digit, pwm and snapshot state of cycle t.
REQ-016 SHALL pulse frame_start for exactly one cycle, one cycle after each snapshot load, including the first load after reset.
REQ-017 SHALL drive, for tick >= 1, an_n with only the current digit's bit low, and only when pwm_cnt <= brightness; otherwise an_n = 6'h3F.
REQ-018 SHALL free-run pwm_cnt as a 3-bit counter wrapping 7->0, so brightness = 7 keeps the digit enabled for the whole non-dead time.
REQ-019 SHALL decode digit values 0-9 to 40,79,24,30,19,12,02,78,00,10 (hex); values 10-15 SHALL show a dash (7'h3F).
REQ-020 SHALL blank the hour_tens digit (seg_n = 7'h7F) when snapshot hour_tens == 0 (leading-zero blanking); its anode still scans.
REQ-021 SHALL light dp_n = 0 on digits 2 and 4 when snapshot sec_units is even (colon blink), and on digit 0 when snapshot is_am == 0 (PM indicator); dp_n = 1 on all other digits.
REQ-022 SHALL keep every segment and anode decision within a slot consistent with that slot's digit index; a slot shall never show two digits' data.

Reset
REQ-023 SHALL, while rst is high, force tick = 0, digit = 0 and pwm_cnt = 0; snapshot digits = 0 and snapshot is_am = 1; seg_n = 7'h7F, dp_n = 1, an_n = 6'h3F, frame_start = 0.
REQ-024 SHALL, when rst is asserted mid-frame, abandon the frame; the first cycle after deassertion SHALL be digit 0, tick 0, with a snapshot load and frame_start in the following cycle.

Verification (CLK_FREQ = 80, DIGIT_RATE = 10, so TICKS = 8)
REQ-025 SHALL cover: reset released, time 12:34:56 PM, brightness = 7 -> frame_start 1 cycle after release; per 8-cycle slot, 1 dead cycle then 7 cycles of digits 6,5,4,3,2,1 (seg 02,12,19,30,24,79); dp_n = 0 on digit 0 (PM) and digits 2 and 4 (56 is even).
REQ-026 SHALL cover: hour_tens = 0, hour_units = 9 -> digit 5 slot shows seg_n = 7'h7F with an_n[5] low; digit 4 shows 7'h10.
REQ-027 SHALL cover: inputs changed at digit 3 mid-frame -> displayed values unchanged until after the next frame_start.
REQ-028 SHALL cover: brightness = 0 -> an_n active exactly in cycles where pwm_cnt == 0, never in dead cycles.
REQ-029 SHALL cover: sec_units = 4'hB -> digit 0 shows 7'h3F (dash).
REQ-030 SHALL cover: rst pulsed during digit 4 -> all outputs reach reset values the next cycle; the scan restarts at digit 0 with a frame_start pulse.
